// File: rtl/codec_pipe_if.sv
// Handshake bundle for codec_pipe. The upstream stage offers beats on the
// in_* side and the downstream stage takes results from the out_* side.
// The master modport belongs to whoever drives the block; the slave modport
// belongs to codec_pipe itself.
interface codec_pipe_if #(
  parameter int N = 2
);
  localparam int W = 1 << N;

  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_addr;
  logic [W-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_onehot;
  logic [N-1:0] out_addr;
  logic         out_hit;
  logic         busy;

  modport master (
    output mode, in_valid, in_addr, in_vec, out_ready,
    input  in_ready, out_valid, out_onehot, out_addr, out_hit, busy
  );

  modport slave (
    input  mode, in_valid, in_addr, in_vec, out_ready,
    output in_ready, out_valid, out_onehot, out_addr, out_hit, busy
  );
endinterface

// File: rtl/codec_pipe.sv
// codec_pipe: registered N-bit decoder / W-bit priority encoder / one-hot
// sweep generator behind a single output register with valid/ready on both
// sides. One beat is held at a time; a sweep turns one accepted beat into W
// output beats and blocks the input until the last one is consumed.
module codec_pipe #(
  parameter int N = 2
) (
  input logic         clk,
  input logic         rst,
  codec_pipe_if.slave bus
);
  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t       r_state, w_state_next;
  logic [W-1:0] r_onehot, w_onehot_next;
  logic [N-1:0] r_addr, w_addr_next;
  logic         r_hit, w_hit_next;
  logic [N-1:0] r_cnt, w_cnt_next;

  logic         w_in_ready;
  logic         w_accept;
  logic [N-1:0] w_enc_addr;
  logic         w_enc_hit;
  logic         w_last_sweep;

  // A held beat can be replaced in the same cycle it is consumed, which keeps
  // decode/encode at one beat per clock. SWEEP never accepts.
  assign w_in_ready   = (r_state == IDLE) || ((r_state == FULL) && bus.out_ready);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_enc_hit    = |bus.in_vec;
  assign w_last_sweep = (r_cnt == N'(W - 1));

  // Priority encoder: scan from the top so the lowest set bit wins.
  always_comb begin
    w_enc_addr = '0;
    for (int j = W - 1; j >= 0; j--) begin
      if (bus.in_vec[j]) begin
        w_enc_addr = N'(j);
      end
    end
  end

  // Next-state and next-output-register logic.
  always_comb begin
    w_state_next  = r_state;
    w_onehot_next = r_onehot;
    w_addr_next   = r_addr;
    w_hit_next    = r_hit;
    w_cnt_next    = r_cnt;

    case (r_state)
      IDLE, FULL: begin
        // Consumption without a replacement empties the register; a
        // reserved-mode beat is swallowed and so also leaves it empty.
        if ((r_state == FULL) && bus.out_ready) begin
          w_state_next = IDLE;
        end
        if (w_accept) begin
          case (bus.mode)
            2'b00: begin
              w_state_next  = FULL;
              w_onehot_next = W'(1) << bus.in_addr;
              w_addr_next   = bus.in_addr;
              w_hit_next    = 1'b1;
            end
            2'b01: begin
              w_state_next  = FULL;
              w_onehot_next = '0;
              w_addr_next   = w_enc_addr;
              w_hit_next    = w_enc_hit;
            end
            2'b10: begin
              w_state_next  = SWEEP;
              w_onehot_next = W'(1) << bus.in_addr;
              w_addr_next   = bus.in_addr;
              w_hit_next    = 1'b1;
              w_cnt_next    = '0;
            end
            default: begin
            end
          endcase
        end
      end

      SWEEP: begin
        // r_cnt counts consumed sweep beats; the W-th consumption ends the sweep.
        if (bus.out_ready) begin
          if (w_last_sweep) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_onehot_next = {r_onehot[W-2:0], r_onehot[W-1]};
            w_addr_next   = r_addr + N'(1);
            w_cnt_next    = r_cnt + N'(1);
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any held or sweeping beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_onehot <= '0;
      r_addr   <= '0;
      r_hit    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_onehot <= w_onehot_next;
      r_addr   <= w_addr_next;
      r_hit    <= w_hit_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state != IDLE);
  assign bus.busy       = (r_state == SWEEP);
  assign bus.out_onehot = r_onehot;
  assign bus.out_addr   = r_addr;
  assign bus.out_hit    = r_hit;
endmodule
